// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS frequency-hop sequencer.
// Ping-pong index walk is enabled by DDS_HOP_PINGPONG_EN.
package dds_pkg;
  localparam int NUM_STEPS  = 16;
  localparam int STEP_IDX_W = $clog2(NUM_STEPS);
  localparam int PHASE_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DWELL,
    DONE
  } hop_state_t;

  typedef logic [PHASE_W-1:0] phase_inc_t;
endpackage

// File: rtl/dds_hop_sequencer_dwell_timer.sv
// Dwell down-counter: load a count, decrement while running,
// flag expiry on the last held clock.
module dds_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (run && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = run && (count == DWELL_W'(1));

endmodule

// File: rtl/dds_hop_sequencer.sv
// Walks the coarse phase-increment table toward the DDS core.
// Define DDS_HOP_PINGPONG_EN for a bouncing index in continuous mode.
module dds_hop_sequencer #(
  parameter int NUM_STEPS = dds_pkg::NUM_STEPS,
  parameter int PHASE_W   = dds_pkg::PHASE_W,
  parameter int DWELL_W   = 24
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_STEPS-1:0][PHASE_W-1:0]   i_coarse_step_rom,
  input  logic                                i_enable,
  input  logic                                i_tipo_ajuste,
  input  logic                                i_start,
  input  logic [DWELL_W-1:0]                  i_dwell_cycles,
  output logic [PHASE_W-1:0]                  o_phase_inc,
  output logic                                o_inc_valid,
  input  logic                                i_inc_ready,
  output logic [$clog2(NUM_STEPS)-1:0]        o_step_idx,
  output logic                                o_busy,
  output logic                                o_done
);
  import dds_pkg::*;

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STEPS - 1);

  hop_state_t         state, state_n;
  logic [IDX_W-1:0]   idx_n;
  logic [DWELL_W-1:0] dwell_q;
  logic               mode_q;
  logic               launch;
  logic               load_rom;
  logic               expire;

`ifdef DDS_HOP_PINGPONG_EN
  logic dir_q, dir_n;
`endif

  dds_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk   (clock),
    .rst_n (reset_n),
    .load  (state == LOAD && i_inc_ready),
    .run   (state == DWELL),
    .value (dwell_q),
    .expire(expire)
  );

  always_comb begin
    state_n = state;
    idx_n   = o_step_idx;
    launch  = 1'b0;
`ifdef DDS_HOP_PINGPONG_EN
    dir_n   = dir_q;
`endif
    unique case (state)
      IDLE: begin
        if (i_start && i_enable) begin
          state_n = LOAD;
          idx_n   = '0;
          launch  = 1'b1;
`ifdef DDS_HOP_PINGPONG_EN
          dir_n   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (!i_enable) state_n = IDLE;
        else if (i_inc_ready) state_n = DWELL;
      end
      DWELL: begin
        if (!i_enable) begin
          state_n = IDLE;
        end else if (expire) begin
          state_n = LOAD;
          idx_n   = o_step_idx + 1'b1;
`ifdef DDS_HOP_PINGPONG_EN
          // dir_q is only ever set in continuous mode
          if (dir_q) begin
            idx_n = o_step_idx - 1'b1;
            dir_n = (o_step_idx != IDX_W'(1));
          end else
`endif
          if (o_step_idx == LAST) begin
            if (!mode_q) begin
              state_n = DONE;
              idx_n   = o_step_idx;
            end
`ifdef DDS_HOP_PINGPONG_EN
            else begin
              idx_n = LAST - 1'b1;
              dir_n = 1'b1;
            end
`endif
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Table is sampled only on the edge that enters LOAD
  assign load_rom = (state_n == LOAD) && (state != LOAD);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      o_step_idx  <= '0;
      o_phase_inc <= '0;
      o_inc_valid <= 1'b0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
    end else begin
      state       <= state_n;
      o_step_idx  <= idx_n;
      o_inc_valid <= (state_n == LOAD);
      if (load_rom) o_phase_inc <= i_coarse_step_rom[idx_n];
      if (launch) begin
        dwell_q <= (i_dwell_cycles == '0) ? DWELL_W'(1) : i_dwell_cycles;
        mode_q  <= i_tipo_ajuste;
      end
    end
  end

`ifdef DDS_HOP_PINGPONG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dir_q <= 1'b0;
    else          dir_q <= dir_n;
  end
`endif

  assign o_busy = (state == LOAD) || (state == DWELL);
  assign o_done = (state == DONE);

endmodule

// File: doc/dds_hop_sequencer.md
Name: dds_hop_sequencer

Overview:
- Frequency-hop sequencer between the Avalon-MM register slave and the DDS phase accumulator.
- On a start pulse, walks the 16-entry coarse phase-increment table in order and presents each entry to the DDS core with a valid/ready handshake.
- Holds each entry for a programmable dwell time.
- Runs one-shot or continuous, selected by the slave's tipo_ajuste bit.

Parameters:
- NUM_STEPS, 16, table depth; must be a power of 2.
- PHASE_W, 32, phase-increment width.
- DWELL_W, 24, dwell counter width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- i_coarse_step_rom  in  PHASE_W x NUM_STEPS  increment table from the register slave
- i_enable  in  1  global enable; low aborts any sequence
- i_tipo_ajuste  in  1  0 = one-shot sweep, 1 = continuous loop
- i_start  in  1  single-cycle start pulse
- i_dwell_cycles  in  DWELL_W  clocks to hold each step
- o_phase_inc  out  PHASE_W  increment presented to the DDS
- o_inc_valid  out  1  o_phase_inc is a new value
- i_inc_ready  in  1  DDS accepts the increment
- o_step_idx  out  log2(NUM_STEPS)  current table index
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle pulse when a one-shot sweep completes

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0; dwell latch 0.
- States: IDLE, LOAD, DWELL, DONE.
- IDLE:
  - o_busy=0.
  - i_start && i_enable → LOAD next cycle, with idx=0.
  - Same cycle: latch i_dwell_cycles and i_tipo_ajuste; both are then fixed for the whole run.
  - A latched dwell of 0 is treated as 1.
- LOAD:
  - On entry, register o_phase_inc = i_coarse_step_rom[idx].
  - The table is sampled only here; host writes during DWELL affect later steps only.
  - o_inc_valid=1; o_phase_inc and o_inc_valid stay stable until i_inc_ready.
  - On valid && ready → DWELL, with counter = dwell.
- DWELL:
  - o_inc_valid=0; counter decrements each clock.
  - At counter==1:
    - idx<NUM_STEPS-1 → idx+1, LOAD.
    - idx==NUM_STEPS-1 and mode 0 → DONE.
    - idx==NUM_STEPS-1 and mode 1 → idx wraps to 0, LOAD.
- DONE: o_done=1 for exactly one cycle → IDLE. o_phase_inc keeps the last value, so the DDS stays on the final tone.
- Timing:
  - i_start at cycle N → o_inc_valid high at cycle N+1.
  - With ready tied high, each step lasts dwell+1 clocks.
- o_busy=1 in LOAD and DWELL only.
- i_start while busy is ignored.
- i_enable low in any non-IDLE state:
  - → IDLE next cycle; o_inc_valid drops; no o_done pulse.
  - o_step_idx and o_phase_inc hold their last values.
- i_start and i_enable falling in the same IDLE cycle: no start.
- A reset mid-sequence takes effect immediately; outputs go to their reset values.

Optional Feature:
- Macro: DDS_HOP_PINGPONG_EN.
- Defined: in mode 1 the index reverses direction at the ends: 0..15, 14..1, 0, 1, ... End entries are not repeated. Direction resets to ascending on every start. Mode 0 is unchanged.
- Undefined: mode 1 wraps 15→0; no direction register is built.

Decomposition:
- Package dds_pkg holds:
  - constants NUM_STEPS, STEP_IDX_W, PHASE_W;
  - typedef hop_state_t, an enum of IDLE/LOAD/DWELL/DONE;
  - typedef phase_inc_t = logic [PHASE_W-1:0].
- One sub-module, dds_dwell_timer: load / decrement / expire pulse, parameterised by DWELL_W.
- The FSM and index logic stay in the top module.

Test Plan:
- One-shot: table[k]=k+1, dwell=3, mode 0, ready=1, start → o_phase_inc steps 1..16, each held 4 clocks; o_done one cycle after step 16's dwell; o_busy low afterwards; o_phase_inc stays 16.
- Handshake: ready low for 5 cycles in step 2 → o_inc_valid and o_phase_inc=3 held stable; dwell count starts only after ready.
- Continuous: mode 1, dwell=1 → idx sequence 15→0 wraps with no o_done. Second start while busy is ignored.
- Abort: drop i_enable mid-step 7 → next cycle IDLE; o_busy=0, o_inc_valid=0, no o_done; restart begins at idx 0.
- Edge values: dwell=0 behaves as dwell=1. Table write to entry 5 during step 3 dwell → step 5 outputs the new value. Async reset mid-DWELL → all outputs 0 immediately.
- With DDS_HOP_PINGPONG_EN: mode 1 idx sequence 14,15,14,...,1,0,1.
